// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic fa_sum(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   function automatic logic fa_carry(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_bit_counter.sv
// Bit counter for the serial adder: counts processed bits and flags the last one.
module serial_bit_counter #(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear,
   input  logic en,
   output logic last
);

   logic [CNT_W-1:0] count;

   // Count enabled cycles; clear takes priority so a new operation starts at zero.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: operand handshake, LSB-first add, result handshake.
// Optional macro SERIAL_ADD_SUB_EN adds sub_i for A-B (carry_o=1 means no borrow).
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready_o high
// SHIFT | one bit per cycle through the full adder, WIDTH cycles
// DONE  | result presented, held until sum_ready_i
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub_i,
`endif
   output logic             sum_valid_o,
   input  logic             sum_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             busy_o
);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] sum_sr;
   logic             carry;
   logic             bit_s;
   logic             bit_c;
   logic [WIDTH-1:0] sum_shift;
   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             accept;
   logic             last;

   assign accept    = in_valid_i && in_ready_o;
   assign bit_s     = fa_sum(a_sr[0], b_sr[0], carry);
   assign bit_c     = fa_carry(a_sr[0], b_sr[0], carry);
   // New bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
   assign sum_shift = {bit_s, sum_sr};

`ifdef SERIAL_ADD_SUB_EN
   // Subtraction as A + ~B + 1.
   assign b_load = sub_i ? ~b_i : b_i;
   assign c_load = sub_i;
`else
   assign b_load = b_i;
   assign c_load = 1'b0;
`endif

   serial_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear   (accept),
      .en      (state == SHIFT),
      .last    (last)
   );

   // Sequencer with datapath registers and registered handshake outputs.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state       <= IDLE;
         a_sr        <= '0;
         b_sr        <= '0;
         sum_sr      <= '0;
         carry       <= 1'b0;
         sum_o       <= '0;
         carry_o     <= 1'b0;
         sum_valid_o <= 1'b0;
         busy_o      <= 1'b0;
         in_ready_o  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_sr       <= a_i;
                  b_sr       <= b_load;
                  carry      <= c_load;
                  sum_sr     <= '0;
                  state      <= SHIFT;
                  in_ready_o <= 1'b0;
                  busy_o     <= 1'b1;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_shift[WIDTH-1:1];
               carry  <= bit_c;
               if (last) begin
                  state       <= DONE;
                  sum_o       <= sum_shift;
                  carry_o     <= bit_c;
                  sum_valid_o <= 1'b1;
               end
            end
            DONE: begin
               if (sum_ready_i) begin
                  state       <= IDLE;
                  sum_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
                  in_ready_o  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               sum_valid_o <= 1'b0;
               busy_o      <= 1'b0;
               in_ready_o  <= 1'b1;
            end
         endcase
      end
   end

endmodule
